// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter with starvation override and a post-flush drain window.
// Optional BR_PRIORITY_EN macro lets requester BR_IDX beat rotation (starved requesters still win).
module cdb_rr_arbiter #(
   parameter int unsigned NUM_REQ      = 5,
   parameter int unsigned STARVE_MAX   = 8,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned BR_IDX       = 2,
   localparam int unsigned IdxW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               commit_mis_pred,
   input  logic               cdb_stall,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IdxW-1:0]    gnt_idx,
   output logic               draining,
   output logic               starve_flag
);

   localparam int unsigned CntW   = $clog2(STARVE_MAX + 1);
   localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CntW-1:0]   StarveMax = CntW'(STARVE_MAX);
   localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);
   localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_REQ - 1);

   if (BR_IDX >= NUM_REQ || DRAIN_CYCLES < 1) begin : g_bad_cfg
      $error("cdb_rr_arbiter: BR_IDX must be < NUM_REQ and DRAIN_CYCLES >= 1");
   end

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e                         r_state, w_state_d;
   logic [DrainW-1:0]              r_drain_cnt, w_drain_cnt_d;
   logic [IdxW-1:0]                r_rr_ptr, w_rr_ptr_d;
   logic [NUM_REQ-1:0][CntW-1:0]   r_starve_cnt, w_starve_cnt_d;

   logic                w_grant_en;
   logic                w_sel_found;
   logic [IdxW-1:0]     w_sel_idx;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [NUM_REQ-1:0]  w_starved;

   assign w_grant_en = reset_n && (r_state == StRun) && !commit_mis_pred && !cdb_stall && |req;

   always_comb begin
      w_starved = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_starved[i] = (r_starve_cnt[i] == StarveMax);
      end
   end

   // Priority: lowest-index starved requester, then (optionally) BR, then rotation from rr_ptr.
   always_comb begin
      int unsigned pos;
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      pos         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_sel_found && req[i] && w_starved[i]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IdxW'(i);
         end
      end
`ifdef BR_PRIORITY_EN
      if (!w_sel_found && req[BR_IDX]) begin
         w_sel_found = 1'b1;
         w_sel_idx   = IdxW'(BR_IDX);
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(unsigned'(r_rr_ptr)) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!w_sel_found && req[pos]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = IdxW'(pos);
         end
      end
   end

   always_comb begin
      w_gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_gnt[i] = w_grant_en && w_sel_found && (w_sel_idx == IdxW'(i));
      end
   end

   assign gnt         = w_gnt;
   assign gnt_valid   = |w_gnt;
   assign gnt_idx     = (|w_gnt) ? w_sel_idx : '0;
   assign draining    = reset_n && (r_state == StDrain);
   assign starve_flag = reset_n && |w_starved;

   always_comb begin
      w_state_d      = r_state;
      w_drain_cnt_d  = r_drain_cnt;
      w_rr_ptr_d     = r_rr_ptr;
      w_starve_cnt_d = r_starve_cnt;
      unique case (r_state)
         StRun: begin
            if (commit_mis_pred) begin
               w_state_d      = StDrain;
               w_drain_cnt_d  = DrainLoad;
               w_starve_cnt_d = '0;
            end else begin
               if (|w_gnt) begin
                  w_rr_ptr_d = (w_sel_idx == LastIdx) ? '0 : w_sel_idx + 1'b1;
               end
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (req[i] && !w_gnt[i]) begin
                     if (!w_starved[i]) w_starve_cnt_d[i] = r_starve_cnt[i] + 1'b1;
                  end else begin
                     w_starve_cnt_d[i] = '0;
                  end
               end
            end
         end
         StDrain: begin
            w_starve_cnt_d = '0;
            if (commit_mis_pred) begin
               w_drain_cnt_d = DrainLoad;
            end else if (r_drain_cnt == '0) begin
               w_state_d = StRun;
            end else begin
               w_drain_cnt_d = r_drain_cnt - 1'b1;
            end
         end
         default: w_state_d = StRun;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StRun;
         r_drain_cnt  <= '0;
         r_rr_ptr     <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_d;
         r_drain_cnt  <= w_drain_cnt_d;
         r_rr_ptr     <= w_rr_ptr_d;
         r_starve_cnt <= w_starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for cdb_rr_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration rules.
module tb_cdb_rr_arbiter;

   localparam int N     = 5;
   localparam int MAX   = 8;
   localparam int DRAIN = 2;
   localparam int BR    = 2;

   logic         clock;
   logic         reset_n;
   logic         tb_flush;
   logic         tb_stall;
   logic [N-1:0] tb_req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [2:0]   gnt_idx;
   logic         draining;
   logic         starve_flag;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   int m_rr;
   int m_drain;
   int m_cnt[N];

   cdb_rr_arbiter #(
      .NUM_REQ     (N),
      .STARVE_MAX  (MAX),
      .DRAIN_CYCLES(DRAIN),
      .BR_IDX      (BR)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .commit_mis_pred(tb_flush),
      .cdb_stall      (tb_stall),
      .req            (tb_req),
      .gnt            (gnt),
      .gnt_valid      (gnt_valid),
      .gnt_idx        (gnt_idx),
      .draining       (draining),
      .starve_flag    (starve_flag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   wire [10:0] obs = {gnt, gnt_valid, gnt_idx, draining, starve_flag};

   function automatic void model_reset();
      m_rr    = 0;
      m_drain = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endfunction

   function automatic int model_pick();
      if (m_drain != 0 || tb_flush || tb_stall || tb_req == '0) return -1;
      for (int i = 0; i < N; i++) if (tb_req[i] && m_cnt[i] >= MAX) return i;
`ifdef BR_PRIORITY_EN
      if (tb_req[BR]) return BR;
`endif
      for (int k = 0; k < N; k++) if (tb_req[(m_rr + k) % N]) return (m_rr + k) % N;
      return -1;
   endfunction

   function automatic logic [10:0] model_outputs();
      int         g;
      logic [4:0] eg;
      logic [2:0] ei;
      logic       sf;
      g  = model_pick();
      eg = '0;
      ei = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ei    = 3'(g);
      end
      sf = 1'b0;
      for (int i = 0; i < N; i++) if (m_cnt[i] == MAX) sf = 1'b1;
      return {eg, g >= 0, ei, m_drain > 0, sf};
   endfunction

   function automatic void model_update(input int g);
      if (m_drain == 0) begin
         if (tb_flush) begin
            m_drain = DRAIN;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
         end else begin
            if (g >= 0) m_rr = (g + 1) % N;
            for (int i = 0; i < N; i++)
               m_cnt[i] = (tb_req[i] && i != g) ? ((m_cnt[i] + 1 > MAX) ? MAX : m_cnt[i] + 1) : 0;
         end
      end else begin
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
         m_drain = tb_flush ? DRAIN : m_drain - 1;
      end
   endfunction

   // Apply inputs just after a posedge and move to the sampling point (negedge).
   task automatic apply(input logic [N-1:0] r, input logic s, input logic f);
      tb_req   = r;
      tb_stall = s;
      tb_flush = f;
      @(negedge clock);
   endtask

   task automatic tick();
      int g;
      g = model_pick();
      @(posedge clock);
      model_update(g);
      #1;
   endtask

   task automatic do_reset();
      tb_req   = '0;
      tb_stall = 1'b0;
      tb_flush = 1'b0;
      reset_n  = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      tb_req   = 5'b11111;
      tb_stall = 1'b0;
      tb_flush = 1'b0;
      #3;
      n_cmp++;
      if (obs !== 11'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want %b", obs, 11'd0);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs !== 11'd0) begin
         n_err++;
         $display("FAIL reset_after_edge: got %b want %b", obs, 11'd0);
      end
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] e;
      for (int k = 0; k < 6; k++) begin
         apply(5'b11111, 1'b0, 1'b0);
         e = '0;
         e[k % N] = 1'b1;
         n_cmp++;
         if (gnt !== e || gnt_valid !== 1'b1 || gnt_idx !== 3'(k % N)) begin
            n_err++;
            $display("FAIL rr_seq[%0d]: gnt=%b idx=%0d want gnt=%b idx=%0d", k, gnt, gnt_idx, e,
                     k % N);
         end
         tick();
      end
   endtask

   task automatic test_two_req();
      logic [N-1:0] eg[3] = '{5'b00001, 5'b00100, 5'b00001};
      logic [2:0]   ei[3] = '{3'd0, 3'd2, 3'd0};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         apply(5'b00101, 1'b0, 1'b0);
         n_cmp++;
         if (gnt !== eg[k] || gnt_idx !== ei[k]) begin
            n_err++;
            $display("FAIL two_req[%0d]: gnt=%b idx=%0d want gnt=%b idx=%0d", k, gnt, gnt_idx,
                     eg[k], ei[k]);
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      logic [N-1:0] eg;
      logic         ef;
      do_reset();
`ifdef BR_PRIORITY_EN
      for (int k = 1; k <= 10; k++) begin
         apply(5'b10100, 1'b0, 1'b0);
         eg = (k == 9) ? 5'b10000 : 5'b00100;
         ef = (k == 9);
         n_cmp++;
         if (gnt !== eg || starve_flag !== ef) begin
            n_err++;
            $display("FAIL starve_br[%0d]: gnt=%b flag=%b want gnt=%b flag=%b", k, gnt,
                     starve_flag, eg, ef);
         end
         tick();
      end
`else
      // Stalling lets both requesters lose until they saturate.
      for (int k = 0; k <= MAX; k++) begin
         apply(5'b10100, (k < MAX), 1'b0);
         eg = (k < MAX) ? 5'b00000 : 5'b00100;
         ef = (k == MAX);
         n_cmp++;
         if (gnt !== eg || starve_flag !== ef) begin
            n_err++;
            $display("FAIL starve_stall[%0d]: gnt=%b flag=%b want gnt=%b flag=%b", k, gnt,
                     starve_flag, eg, ef);
         end
         tick();
      end
      apply(5'b10100, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== 5'b10000 || starve_flag !== 1'b1) begin
         n_err++;
         $display("FAIL starve_second: gnt=%b flag=%b want gnt=10000 flag=1", gnt, starve_flag);
      end
      tick();
      apply(5'b10100, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== 5'b00100 || starve_flag !== 1'b0) begin
         n_err++;
         $display("FAIL starve_recover: gnt=%b flag=%b want gnt=00100 flag=0", gnt, starve_flag);
      end
      tick();
`endif
   endtask

   task automatic test_flush();
      logic [N-1:0] eg;
      logic         ed;
      do_reset();
      apply(5'b11111, 1'b0, 1'b0);
      tick();
      apply(5'b11111, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         apply(5'b11111, 1'b0, (k == 0));
         eg = (k == 3) ? 5'b00100 : 5'b00000;
         ed = (k == 1 || k == 2);
         n_cmp++;
         if (gnt !== eg || draining !== ed) begin
            n_err++;
            $display("FAIL flush[t+%0d]: gnt=%b drain=%b want gnt=%b drain=%b", k, gnt, draining,
                     eg, ed);
         end
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         apply(5'b11111, 1'b0, (k <= 1));
         eg = (k == 4) ? 5'b01000 : 5'b00000;
         ed = (k >= 1 && k <= 3);
         n_cmp++;
         if (gnt !== eg || draining !== ed) begin
            n_err++;
            $display("FAIL reflush[t+%0d]: gnt=%b drain=%b want gnt=%b drain=%b", k, gnt,
                     draining, eg, ed);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      apply(5'b11111, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         apply(5'b00100, 1'b1, 1'b0);
         n_cmp++;
         if (gnt !== 5'b0 || gnt_valid !== 1'b0 || starve_flag !== 1'b0) begin
            n_err++;
            $display("FAIL stall[%0d]: gnt=%b valid=%b flag=%b want 00000/0/0", k, gnt, gnt_valid,
                     starve_flag);
         end
         tick();
      end
      apply(5'b11111, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== 5'b00010 || gnt_idx !== 3'd1) begin
         n_err++;
         $display("FAIL stall_release: gnt=%b idx=%0d want gnt=00010 idx=1", gnt, gnt_idx);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(5'b11111, 1'b0, 1'b1);
      tick();
      apply(5'b11111, 1'b0, 1'b0);
      n_cmp++;
      if (draining !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre: draining=%b want 1", draining);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 11'd0) begin
         n_err++;
         $display("FAIL async_mid_drain: got %b want %b", obs, 11'd0);
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
      apply(5'b11111, 1'b0, 1'b0);
      n_cmp++;
      if (gnt !== 5'b00001 || draining !== 1'b0 || starve_flag !== 1'b0) begin
         n_err++;
         $display("FAIL async_release: gnt=%b drain=%b flag=%b want 00001/0/0", gnt, draining,
                  starve_flag);
      end
      tick();
   endtask

   task automatic test_random();
      logic [10:0]  e;
      logic [N-1:0] r;
      logic         s;
      logic         f;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         r = (c % 3 == 0) ? N'($urandom) & N'($urandom) : N'($urandom);
         s = ($urandom_range(0, 99) < ((c % 400) < 200 ? 15 : 70));
         f = ($urandom_range(0, 29) == 0);
         apply(r, s, f);
         e = model_outputs();
         n_cmp++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL random[%0d] req=%b stall=%b flush=%b: got %b want %b", c, r, s, f,
                     obs, e);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_two_req();
      test_starvation();
      test_flush();
      test_stall();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
